multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle main decoder with a Moore FSM that time-shares one ALU and one unified memory port across instruction phases. Each cycle it drives the enables and mux selects for the PC, IR, register file, memory port and `ALU_Control`. Memory phases stall on a ready handshake.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mc_output_decode.sv | 73 +++++++
 rtl/multicycle_control.sv | 102 ++++++++++
 tb/tb_multicycle_control.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU/PC mux selects and the per-cycle control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXEC    = 4'd7,
    S_ALU_WB  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Pure Moore decode of FSM state into the datapath control word.
// Handshake-gated strobes are left at 0 here and added by the top.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      // Branch target is precomputed here while the opcode is still decoding.
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register plus combinational next-state,
// with memory phases stalled on mem_ready.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     state_dbg
);

  state_e      state_q, state_d;
  ctrl_t       ctrl;
  logic [5:0]  op6;
  logic        illegal;
  logic        fetch_done;
  logic        store_done;

  assign op6 = 6'(opcode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(op6))     state_d = S_MEM_ADR;
        else if (op6 == OP_RTYPE) state_d = S_EXEC;
        else if (op6 == OP_ADDI)  state_d = S_ADDI_EX;
        else if (op6 == OP_BEQ)   state_d = S_BRANCH;
        else if (op6 == OP_J)     state_d = S_JUMP;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEM_ADR: begin
        if (op6 == OP_LW)      state_d = S_MEM_RD;
        else if (op6 == OP_SW) state_d = S_MEM_WR;
        else                   state_d = S_FETCH;
      end
      S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALU_WB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  mc_output_decode u_dec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // IR/PC load and store completion fire only on the cycle memory finishes,
  // so a stalled fetch or store never double-commits.
  assign fetch_done = (state_q == S_FETCH)  && mem_ready;
  assign store_done = (state_q == S_MEM_WR) && mem_ready;

  assign pc_write      = ctrl.pc_write | fetch_done;
  assign ir_write      = ctrl.ir_write | fetch_done;
  assign instr_done    = ctrl.instr_done | store_done;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: walks each instruction class cycle by cycle and compares the
// full control vector against hand-written per-state expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  logic [21:0] obs;

  int total = 0;
  int fails = 0;

  localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADR = 3, MEM_RD = 4,
                         MEM_WB = 5, MEM_WR = 6, EXEC = 7, ALU_WB = 8, ADDI_EX = 9,
                         ADDI_WB = 10, BRANCH = 11, JUMP = 12;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op, state_dbg};

  // Expected control vector for a state, from the state table.
  function automatic logic [21:0] cw(input logic [3:0] st, input logic mr, input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, idn, il;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, idn, il} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      FETCH:   begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
      DECODE:  begin sb = 2'b11; il = ill; end
      MEM_ADR: begin sa = 1; sb = 2'b10; end
      MEM_RD:  begin mrd = 1; iod = 1; end
      MEM_WB:  begin rw = 1; m2r = 1; idn = 1; end
      MEM_WR:  begin mwr = 1; iod = 1; idn = mr; end
      EXEC:    begin sa = 1; ao = 2'b10; end
      ALU_WB:  begin rw = 1; rd = 1; idn = 1; end
      ADDI_EX: begin sa = 1; sb = 2'b10; end
      ADDI_WB: begin rw = 1; idn = 1; end
      BRANCH:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; idn = 1; end
      JUMP:    begin pw = 1; ps = 2'b10; idn = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, idn, il, st};
  endfunction

  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    total++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%06h expected=%06h", tag, o, e);
    end
  endtask

  // One clock cycle: apply mem_ready, sample mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic mr, input logic ill);
    mem_ready = mr;
    #4;
    chk(tag, obs, cw(st, mr, ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    #2;
    chk("reset_all_zero", obs, 22'd0);
    @(posedge clk); #1;
    chk("reset_held", obs, 22'd0);
    reset = 1'b0;
    cyc("idle_after_release", IDLE, 1'b1, 1'b0);

    // lw, no stalls: 5 cycles
    opcode = 6'b100011;
    cyc("lw_fetch", FETCH, 1'b1, 1'b0);
    cyc("lw_decode", DECODE, 1'b0, 1'b0);
    cyc("lw_adr", MEM_ADR, 1'b0, 1'b0);
    cyc("lw_rd", MEM_RD, 1'b1, 1'b0);
    cyc("lw_wb", MEM_WB, 1'b0, 1'b0);

    // lw with a one-cycle fetch stall and three-cycle read stall
    cyc("lw2_fetch_stall", FETCH, 1'b0, 1'b0);
    cyc("lw2_fetch", FETCH, 1'b1, 1'b0);
    cyc("lw2_decode", DECODE, 1'b1, 1'b0);
    cyc("lw2_adr", MEM_ADR, 1'b1, 1'b0);
    cyc("lw2_rd_stall0", MEM_RD, 1'b0, 1'b0);
    cyc("lw2_rd_stall1", MEM_RD, 1'b0, 1'b0);
    cyc("lw2_rd_stall2", MEM_RD, 1'b0, 1'b0);
    cyc("lw2_rd", MEM_RD, 1'b1, 1'b0);
    cyc("lw2_wb", MEM_WB, 1'b0, 1'b0);

    // R-type
    opcode = 6'b000000;
    cyc("r_fetch", FETCH, 1'b1, 1'b0);
    cyc("r_decode", DECODE, 1'b0, 1'b0);
    cyc("r_exec", EXEC, 1'b1, 1'b0);
    cyc("r_wb", ALU_WB, 1'b1, 1'b0);

    // sw with one stall cycle in MEM_WR
    opcode = 6'b101011;
    cyc("sw_fetch", FETCH, 1'b1, 1'b0);
    cyc("sw_decode", DECODE, 1'b1, 1'b0);
    cyc("sw_adr", MEM_ADR, 1'b1, 1'b0);
    cyc("sw_wr_stall", MEM_WR, 1'b0, 1'b0);
    cyc("sw_wr", MEM_WR, 1'b1, 1'b0);

    // addi
    opcode = 6'b001000;
    cyc("addi_fetch", FETCH, 1'b1, 1'b0);
    cyc("addi_decode", DECODE, 1'b1, 1'b0);
    cyc("addi_ex", ADDI_EX, 1'b0, 1'b0);
    cyc("addi_wb", ADDI_WB, 1'b0, 1'b0);

    // beq
    opcode = 6'b000100;
    cyc("beq_fetch", FETCH, 1'b1, 1'b0);
    cyc("beq_decode", DECODE, 1'b1, 1'b0);
    cyc("beq_branch", BRANCH, 1'b0, 1'b0);

    // j
    opcode = 6'b000010;
    cyc("j_fetch", FETCH, 1'b1, 1'b0);
    cyc("j_decode", DECODE, 1'b1, 1'b0);
    cyc("j_jump", JUMP, 1'b1, 1'b0);

    // illegal opcode: two cycles, straight back to FETCH
    opcode = 6'b111111;
    cyc("ill_fetch", FETCH, 1'b1, 1'b0);
    cyc("ill_decode", DECODE, 1'b1, 1'b1);
    opcode = 6'b101011;
    cyc("ill_next_fetch", FETCH, 1'b1, 1'b0);

    // sw aborted by reset while stalled in MEM_WR
    cyc("abort_decode", DECODE, 1'b1, 1'b0);
    cyc("abort_adr", MEM_ADR, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("abort_wr_before", obs, cw(MEM_WR, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    chk("abort_reset_async", obs, 22'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    chk("abort_reset_hold", obs, 22'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("abort_idle", IDLE, 1'b1, 1'b0);
    cyc("abort_fetch", FETCH, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
